// File: rtl/spi2adc.sv
// spi2adc: SPI master that reads one 10-bit MCP3002 sample per 16-clock frame.
// Define SPI2ADC_AUTO_EN to make conversions free-running after the first start.
module spi2adc #(
  parameter int   HALF = 25,
  parameter logic SGL  = 1'b1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       channel,
  input  logic       adc_sdo,
  output logic       adc_cs,
  output logic       adc_sck,
  output logic       adc_sdi,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, DONE, HOLD} state_t;
  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] bit_q, bit_d;
  logic [9:0] sh_q, sh_d, data_q, data_d;
  logic ch_q, ch_d, cs_q, cs_d, sck_q, sck_d, sdi_q, sdi_d;
  logic valid_q, valid_d, busy_q, busy_d;
  logic wrap, launch, relaunch;
  assign wrap = cnt_q == 6'(HALF - 1);
`ifdef SPI2ADC_AUTO_EN
  // busy_q is only high in IDLE after a completed frame, which relaunches it
  assign launch   = start | busy_q;
  assign relaunch = 1'b1;
`else
  assign launch   = start;
  assign relaunch = 1'b0;
`endif
  assign adc_cs     = cs_q;
  assign adc_sck    = sck_q;
  assign adc_sdi    = sdi_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      ch_q    <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      sdi_q   <= sdi_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || state_q == DONE || wrap) ? '0 : cnt_q + 6'd1;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (launch) begin
        state_d = SETUP;
        bit_d   = 5'd1;
      end
      SETUP:  state_d = wrap ? SCK_HI : SETUP;
      SCK_HI: state_d = wrap ? SCK_LO : SCK_HI;
      SCK_LO: if (wrap) begin
        state_d = (bit_q == 5'd16) ? DONE : SCK_HI;
        bit_d   = bit_q + 5'd1;
      end
      DONE:    state_d = HOLD;
      HOLD:    state_d = wrap ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // bit_q holds the current SCK index n; SCK_HI exit drives command bit n+1
  always_comb begin
    ch_d    = ch_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    sdi_d   = sdi_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (launch) begin
        ch_d   = channel;
        busy_d = 1'b1;
        cs_d   = 1'b0;
        sdi_d  = 1'b1;
      end
      SETUP: sck_d = wrap ? 1'b1 : sck_q;
      SCK_HI: if (wrap) begin
        sck_d = 1'b0;
        sdi_d = (bit_q == 5'd1) ? SGL : (bit_q == 5'd2) ? ch_q : (bit_q == 5'd3);
      end
      SCK_LO: if (wrap) begin
        sck_d   = bit_q != 5'd16;
        sh_d    = (bit_q >= 5'd5 && bit_q <= 5'd14) ? {sh_q[8:0], adc_sdo} : sh_q;
        cs_d    = bit_q == 5'd16;
        data_d  = (bit_q == 5'd16) ? sh_q : data_q;
        valid_d = bit_q == 5'd16;
      end
      HOLD: busy_d = wrap ? relaunch : busy_q;
      default: ;
    endcase
  end
endmodule

// File: doc/spi2adc.md
# spi2adc

SPI master that reads one 10-bit sample from an MCP3002 two-channel ADC on the lab board. It is the read-side counterpart of the DAC writer. On a start request it runs one 16-clock SPI frame: it shifts out the command bits, captures the 10-bit result, and presents it on a parallel output with a one-cycle valid strobe. It sits between the ADC pins and the sample-processing logic, in the 50 MHz system clock domain.

## Interface
Parameters:
- `HALF`, default 25: sysclk cycles per SCK half-period. 25 gives 1 MHz SCK. Legal range 2..63.
- `SGL`, default 1'b1: SGL/DIFF command bit. 1 selects single-ended, 0 selects pseudo-differential.

Ports:
- `sysclk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  conversion request; sampled only in IDLE
- `channel`  in  1  ODD/SIGN bit; latched when `start` is accepted
- `adc_sdo`  in  1  serial data from ADC (ADC DOUT)
- `adc_cs`  out  1  chip select, active low
- `adc_sck`  out  1  SPI clock, idle low
- `adc_sdi`  out  1  serial command to ADC (ADC DIN)
- `data_out`  out  10  last completed sample, MSB first as received
- `data_valid`  out  1  one-cycle strobe; `data_out` is new in this cycle
- `busy`  out  1  frame in progress, including CS hold

## Operation
- All outputs are registered.
- Reset values: `adc_cs`=1, `adc_sck`=0, `adc_sdi`=0, `data_out`=0, `data_valid`=0, `busy`=0. State is IDLE and all counters are 0.
- A phase counter counts 0..HALF-1. Each wrap ends a phase.
- States:
  - IDLE: if `start`=1, latch `channel`, set `busy`=1, drive `adc_cs`=0 and `adc_sdi`=1 (start bit), then go to SETUP.
  - SETUP: lasts one phase with SCK low, then go to SCK_HI for bit 1.
  - SCK_HI(n), n=1..16: `adc_sck`=1 for one phase. On entry (the SCK rising edge) sample `adc_sdo` into the shift register when n=6..15. n=6 captures B9 and n=15 captures B0. Then go to SCK_LO(n).
  - SCK_LO(n): `adc_sck`=0 for one phase. On entry, drive `adc_sdi` with command bit n+1, then go to SCK_HI(n+1). After SCK_LO(16), go to DONE.
  - DONE: lasts one cycle. `adc_cs`=1, `data_out` takes the shift register value, `data_valid`=1. Then go to HOLD.
  - HOLD: CS stays high for one phase (meets tCSH). Clear `busy` on exit and go to IDLE.
- Command sequence on `adc_sdi`, bits 1..16: 1, SGL, channel, 1 (MSBF), then 0 for bits 5..16.
- The bits received on rising edges 1..5 (high-Z, then the null bit) and edge 16 are discarded.
- `start` is ignored outside IDLE. No queuing.
- Asserting `rst_n` low mid-frame forces the reset values immediately. The partial sample is discarded and no `data_valid` is produced.

## Timing
- `start` accepted at sysclk edge t0 → `adc_cs` low from t0.
- First SCK rising edge at t0+HALF.
- `data_valid` high in cycle t0+33·HALF; 825 cycles for HALF=25.
- `busy` low from t0+33·HALF+1+HALF. `start` held high relaunches on the next cycle, giving a frame period of 34·HALF+2 cycles.
- Sampling rule: `adc_sdo` is sampled on SCK rising edges and `adc_sdi` changes on SCK falling edges, so each bit has HALF cycles of setup on both sides.
- SCK duty is exactly 50%.

## Configuration
- `SPI2ADC_AUTO_EN`
  - Defined: from HOLD the FSM relaunches a frame immediately as if `start`=1, using the current `channel` value. Conversion is free-running, `start` is don't-care, and `busy` stays 1 after the first frame.
  - Undefined: a conversion occurs only on an accepted `start`.

## Test plan
- Single conversion, HALF=25, channel=0, ADC model returns 10'h2A5 → `adc_sdi` bits 1–4 = 1,1,0,1. Exactly 16 SCK pulses at 1 MHz. `data_out`=10'h2A5 with `data_valid` for one cycle, 825 cycles after start. `adc_cs` high in the same cycle.
- channel=1, model returns 10'h3FF, then 10'h000 on the next frame → command bits 1,1,1,1. `data_out`=3FF, then 000. No bit leakage between frames.
- Pulse `start` again during SCK bit 8 → ignored. Exactly one `data_valid`. `channel` change mid-frame does not alter bit 3.
- Assert `rst_n` low during SCK_HI(9) → `adc_cs`=1 and `adc_sck`=0 immediately. `data_out` stays 0, with no `data_valid`. A fresh start after release converts correctly.
- `start` held high, HALF=4 → frames launch every 138 cycles. Consecutive `data_valid` pulses are 138 cycles apart.
- `SPI2ADC_AUTO_EN` defined, one start pulse then `start`=0 → conversions repeat continuously at the same period. Each returns the model value.
